pn532_i2c_byte_master: RTL and testbench

- Byte-level I2C master stage directly downstream of the PN532 FireLink bridge controller.
- Accepts one START, STOP, WRITE or READ command at a time over a valid/ready handshake.
- Generates SCL and open-drain SDA control at a fixed bus rate, and returns read data and the ACK bit.
- The top level wires the pins as `sda = sda_oe ? 0 : Z` and `scl = scl_out`.

---
 rtl/pn532_i2c_byte_master_if.sv | 29 ++
 rtl/pn532_i2c_byte_master.sv | 189 ++++++++++++++++++
 tb/tb_pn532_i2c_byte_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pn532_i2c_byte_master_if.sv
// Command handshake and I2C pin bundle between the FireLink bridge controller
// and the byte-level I2C master.
interface pn532_i2c_byte_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] wr_data;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       ack_received;
    logic       done;
    logic       cmd_err;
    logic       busy;
    logic       scl_out;
    logic       sda_oe;
    logic       sda_in;

    // master: the command issuer plus the SDA pin feedback
    modport master (
        output cmd_valid, cmd, wr_data, rd_ack, sda_in,
        input  cmd_ready, rd_data, ack_received, done, cmd_err, busy, scl_out, sda_oe
    );

    // slave: the byte master block executing commands on the bus
    modport slave (
        input  cmd_valid, cmd, wr_data, rd_ack, sda_in,
        output cmd_ready, rd_data, ack_received, done, cmd_err, busy, scl_out, sda_oe
    );
endinterface

// File: rtl/pn532_i2c_byte_master.sv
// Byte-level I2C master: executes START/STOP/WRITE/READ commands one at a time,
// each bus bit split into four equal quarters of QUARTER system clocks.
module pn532_i2c_byte_master #(
    parameter int CLK_HZ = 50_000_000,
    parameter int I2C_HZ = 100_000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    pn532_i2c_byte_master_if.slave       bus
);
    localparam int QUARTER = CLK_HZ / (4 * I2C_HZ);
    localparam int CNT_W   = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUARTER - 1);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_READ  = 2'd3;

    if (QUARTER < 2) begin : g_quarter_check
        $error("pn532_i2c_byte_master: CLK_HZ/(4*I2C_HZ) must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, BITS, ACK, STOP, FINISH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [3:0]       bit_q, bit_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             ack_q, ack_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             scl_hold_q, sda_hold_q;

    logic [1:0]       cmd_q;
    logic [7:0]       wr_q;
    logic [7:0]       rd_sh_q;
    logic             rd_ack_q;
    logic             ack_smp_q;
    logic             sync1_q, sync2_q;

    logic             scl_o, sda_o;
    logic             accept, reject, last_clk, phase_end, sample_clk;

    assign accept     = bus.cmd_valid && (state_q == IDLE || state_q == FINISH);
    assign reject     = (bus.cmd != CMD_START) && !busy_q;
    assign last_clk   = (cnt_q == CNT_LAST);
    assign phase_end  = last_clk && (qtr_q == 2'd3);
    assign sample_clk = last_clk && (qtr_q == 2'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        busy_d    = busy_q;
        err_d     = err_q;
        ack_d     = ack_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE, FINISH: begin
                if (state_q == FINISH) state_d = IDLE;
                if (accept) begin
                    cnt_d = '0;
                    qtr_d = 2'd0;
                    bit_d = 4'd0;
                    if (reject) begin
                        state_d = FINISH;
                        err_d   = 1'b1;
                    end else begin
                        case (bus.cmd)
                            CMD_START: state_d = START;
                            CMD_STOP:  state_d = STOP;
                            default:   state_d = BITS;
                        endcase
                    end
                end
            end
            default: begin
                if (last_clk) begin
                    cnt_d = '0;
                    qtr_d = qtr_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (phase_end) begin
                    case (state_q)
                        START: begin
                            state_d = FINISH;
                            busy_d  = 1'b1;
                            err_d   = 1'b0;
                        end
                        STOP: begin
                            state_d = FINISH;
                            busy_d  = 1'b0;
                            err_d   = 1'b0;
                        end
                        BITS: begin
                            bit_d = bit_q + 4'd1;
                            if (bit_q == 4'd7) state_d = ACK;
                        end
                        ACK: begin
                            state_d = FINISH;
                            err_d   = 1'b0;
                            if (cmd_q == CMD_WRITE) ack_d = ack_smp_q;
                            else                    rd_data_d = rd_sh_q;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Bus levels per quarter; outside a phase the last driven levels are held.
    always_comb begin
        scl_o = scl_hold_q;
        sda_o = sda_hold_q;
        case (state_q)
            START: begin
                case (qtr_q)
                    2'd0:    sda_o = 1'b0;
                    2'd1:    begin scl_o = 1'b1; sda_o = 1'b0; end
                    2'd2:    begin scl_o = 1'b1; sda_o = 1'b1; end
                    default: begin scl_o = 1'b0; sda_o = 1'b1; end
                endcase
            end
            BITS, ACK: begin
                scl_o = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                if (state_q == BITS) sda_o = (cmd_q == CMD_WRITE) && !wr_q[~bit_q[2:0]];
                else                 sda_o = (cmd_q == CMD_READ) && rd_ack_q;
            end
            STOP: begin
                scl_o = (qtr_q != 2'd0);
                sda_o = (qtr_q != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 4'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            scl_hold_q <= 1'b1;
            sda_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
            scl_hold_q <= scl_o;
            sda_hold_q <= sda_o;
        end
    end

    // Command operands and sampled SDA only matter once a phase is running.
    always_ff @(posedge CLOCK_50) begin
        sync1_q <= bus.sda_in;
        sync2_q <= sync1_q;
        if (accept) begin
            cmd_q    <= bus.cmd;
            wr_q     <= bus.wr_data;
            rd_ack_q <= bus.rd_ack;
        end
        if (state_q == BITS && sample_clk) rd_sh_q   <= {rd_sh_q[6:0], sync2_q};
        if (state_q == ACK  && sample_clk) ack_smp_q <= ~sync2_q;
    end

    assign bus.cmd_ready    = (state_q == IDLE) || (state_q == FINISH);
    assign bus.done         = (state_q == FINISH);
    assign bus.cmd_err      = err_q;
    assign bus.busy         = busy_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.ack_received = ack_q;
    assign bus.scl_out      = scl_o;
    assign bus.sda_oe       = sda_o;
endmodule

// File: tb/tb_pn532_i2c_byte_master.sv
// Bench for pn532_i2c_byte_master: a waveform-level bus model predicts every
// cycle of SCL/SDA and status outputs; directed cases plus random command mixes.
module tb_pn532_i2c_byte_master;
    localparam int CLK_HZ = 2_000_000;
    localparam int I2C_HZ = 100_000;
    localparam int Q      = CLK_HZ / (4 * I2C_HZ);
    localparam int BUDGET = 400;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    pn532_i2c_byte_master_if bif ();

    pn532_i2c_byte_master #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bif)
    );

    typedef struct {
        logic       scl;
        logic       sda;
        logic       done;
        logic       rdy;
        logic       busy;
        logic       err;
        logic       ack;
        logic [7:0] rd;
        logic       slv;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic       m_scl = 1'b1, m_sda = 1'b0, m_busy = 1'b0, m_err = 1'b0, m_ack = 1'b0;
    logic [7:0] m_rd  = 8'h00;
    logic       pull  = 1'b0;
    logic       scl_prev = 1'b1;
    logic       rise_bits[$];
    int         errors = 0;
    int         checks = 0;

    // Slave pulls the line low; master pulls low when sda_oe is set.
    assign bif.sda_in = ~(bif.sda_oe | pull);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic scl, input logic sda, input logic done,
                                       input logic rdy, input logic busy, input logic err,
                                       input logic ack, input logic [7:0] rd);
        return {17'd0, scl, sda, done, rdy, busy, err, ack, rd};
    endfunction

    always @(negedge CLOCK_50) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = '{m_scl, m_sda, 1'b0, 1'b1, m_busy, m_err, m_ack, m_rd, 1'b0};
        pull = cur.slv;
        chk("cycle",
            pk(bif.scl_out, bif.sda_oe, bif.done, bif.cmd_ready, bif.busy, bif.cmd_err,
               bif.ack_received, bif.rd_data),
            pk(cur.scl, cur.sda, cur.done, cur.rdy, cur.busy, cur.err, cur.ack, cur.rd));
        if (bif.scl_out && !scl_prev) rise_bits.push_back(~(bif.sda_oe | pull));
        scl_prev = bif.scl_out;
    end

    task automatic add_quarter(input logic s, input logic d, input logic p);
        repeat (Q) exp_q.push_back('{s, d, 1'b0, 1'b0, m_busy, m_err, m_ack, m_rd, p});
    endtask

    // Expected bus waveform for one accepted command, then the done cycle.
    task automatic build(input logic [1:0] c, input logic [7:0] d, input logic ra,
                         input logic [7:0] sb, input logic sa);
        logic s, p;
        if (c != 2'd0 && !m_busy) begin
            m_err = 1'b1;
            exp_q.push_back('{m_scl, m_sda, 1'b1, 1'b1, m_busy, 1'b1, m_ack, m_rd, 1'b0});
            return;
        end
        case (c)
            2'd0: begin
                add_quarter(m_scl, 1'b0, 1'b0);
                add_quarter(1'b1, 1'b0, 1'b0);
                add_quarter(1'b1, 1'b1, 1'b0);
                add_quarter(1'b0, 1'b1, 1'b0);
                m_scl = 1'b0; m_sda = 1'b1; m_busy = 1'b1;
            end
            2'd1: begin
                add_quarter(1'b0, 1'b1, 1'b0);
                add_quarter(1'b1, 1'b1, 1'b0);
                add_quarter(1'b1, 1'b1, 1'b0);
                add_quarter(1'b1, 1'b0, 1'b0);
                m_scl = 1'b1; m_sda = 1'b0; m_busy = 1'b0;
            end
            default: begin
                s = 1'b0;
                for (int b = 0; b < 9; b++) begin
                    if (b < 8) begin
                        s = (c == 2'd2) ? ~d[7-b] : 1'b0;
                        p = (c == 2'd3) ? ~sb[7-b] : 1'b0;
                    end else begin
                        s = (c == 2'd3) ? ra : 1'b0;
                        p = (c == 2'd2) ? sa : 1'b0;
                    end
                    add_quarter(1'b0, s, p);
                    add_quarter(1'b1, s, p);
                    add_quarter(1'b1, s, p);
                    add_quarter(1'b0, s, p);
                end
                m_scl = 1'b0; m_sda = s;
                if (c == 2'd2) m_ack = sa;
                else           m_rd  = sb;
            end
        endcase
        m_err = 1'b0;
        exp_q.push_back('{m_scl, m_sda, 1'b1, 1'b1, m_busy, m_err, m_ack, m_rd, 1'b0});
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_scl",   32'(bif.scl_out),   32'd1);
        chk("rst_sda",   32'(bif.sda_oe),    32'd0);
        chk("rst_ready", 32'(bif.cmd_ready), 32'd1);
        chk("rst_done",  32'(bif.done),      32'd0);
        exp_q.delete();
        m_scl = 1'b1; m_sda = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_ack = 1'b0; m_rd = 8'h00;
        pull = 1'b0;
        bif.cmd_valid = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        #2 reset = 1'b1;
        @(negedge CLOCK_50);
    endtask

    // Called and returns at a falling edge; lat = accept-to-done cycles, -1 if aborted.
    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic ra,
                         input logic [7:0] sb, input logic sa, input int linger,
                         input int abort_at, output int lat);
        int k;
        lat = -1;
        bif.cmd_valid = 1'b1; bif.cmd = c; bif.wr_data = d; bif.rd_ack = ra;
        k = 0;
        while (!bif.cmd_ready && k < BUDGET) begin
            @(negedge CLOCK_50);
            k++;
        end
        if (!bif.cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bif.cmd_valid = 1'b0;
            return;
        end
        @(posedge CLOCK_50);
        build(c, d, ra, sb, sa);
        @(negedge CLOCK_50);
        k = 1;
        if (linger > 0) begin bif.cmd = ~c; bif.wr_data = ~d; end
        else bif.cmd_valid = 1'b0;
        while (!bif.done && k < BUDGET) begin
            if (abort_at > 0 && k == abort_at) begin
                do_reset();
                return;
            end
            @(negedge CLOCK_50);
            k++;
            if (k >= linger) bif.cmd_valid = 1'b0;
        end
        if (!bif.done) chk("done_timeout", 32'd0, 32'd1);
        else lat = k;
    endtask

    function automatic logic [31:0] rises9();
        logic [8:0] rb = 9'd0;
        for (int i = 0; i < rise_bits.size() && i < 9; i++) rb = {rb[7:0], rise_bits[i]};
        return 32'(rb);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [1:0] rc;
        int el;
        bif.cmd_valid = 1'b0; bif.cmd = 2'd0; bif.wr_data = 8'h00; bif.rd_ack = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_scl",   32'(bif.scl_out),   32'd1);
        chk("reset_sda",   32'(bif.sda_oe),    32'd0);
        chk("reset_ready", 32'(bif.cmd_ready), 32'd1);
        chk("reset_busy",  32'(bif.busy),      32'd0);
        chk("reset_rd",    32'(bif.rd_data),   32'h00);
        #2 reset = 1'b1;
        @(negedge CLOCK_50);

        issue(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);
        chk("start_lat",  32'(lat), 32'd21);
        chk("start_busy", 32'(bif.busy), 32'd1);

        rise_bits.delete();
        issue(2'd2, 8'h48, 1'b0, 8'h00, 1'b1, 0, 0, lat);
        chk("write_lat",  32'(lat), 32'd181);
        chk("write_bits", rises9(), 32'h090);
        chk("write_ack",  32'(bif.ack_received), 32'd1);
        chk("write_err",  32'(bif.cmd_err), 32'd0);

        rise_bits.delete();
        issue(2'd3, 8'h00, 1'b0, 8'hA5, 1'b0, 0, 0, lat);
        chk("read_data", 32'(bif.rd_data), 32'hA5);
        chk("read_bits", rises9(), 32'h14B);

        issue(2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);
        chk("stop_lat",  32'(lat), 32'd21);
        chk("stop_busy", 32'(bif.busy), 32'd0);
        chk("stop_scl",  32'(bif.scl_out), 32'd1);

        issue(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);
        issue(2'd2, 8'h3C, 1'b0, 8'h00, 1'b0, 0, 0, lat);
        chk("nack_ack", 32'(bif.ack_received), 32'd0);
        issue(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);
        chk("rstart_lat",  32'(lat), 32'd21);
        chk("rstart_busy", 32'(bif.busy), 32'd1);
        issue(2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);

        for (int c = 1; c < 4; c++) begin
            issue(2'(c), 8'h5A, 1'b1, 8'h00, 1'b0, 0, 0, lat);
            chk("rej_lat", 32'(lat), 32'd1);
            chk("rej_err", 32'(bif.cmd_err), 32'd1);
        end

        issue(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);
        issue(2'd2, 8'hC3, 1'b0, 8'h00, 1'b1, 50, 0, lat);
        chk("linger_lat", 32'(lat), 32'd181);
        @(negedge CLOCK_50);
        chk("linger_nodone", 32'(bif.done), 32'd0);
        issue(2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);

        issue(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);
        issue(2'd2, 8'hA7, 1'b0, 8'h00, 1'b1, 0, 16 * Q + 2, lat);
        chk("abort_lat", 32'(lat), 32'hFFFF_FFFF);
        issue(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);
        chk("post_rst_start", 32'(lat), 32'd21);
        chk("post_rst_busy",  32'(bif.busy), 32'd1);
        issue(2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);

        for (int i = 0; i < 40; i++) begin
            rc = 2'($urandom_range(0, 3));
            if (!m_busy && $urandom_range(0, 3) != 0) rc = 2'd0;
            el = (rc != 2'd0 && !m_busy) ? 1 : ((rc < 2'd2) ? 4 * Q + 1 : 36 * Q + 1);
            issue(rc, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 0, 0, lat);
            chk("rand_lat", 32'(lat), 32'(el));
            repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
        end
        if (m_busy) issue(2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0, lat);
        repeat (3) @(negedge CLOCK_50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
